imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction memory that feeds the fetch/decode path. Receives a
//  length-prefixed byte stream (e.g. from a UART RX), packs it little-endian into 32-bit
//  instruction words and writes them sequentially into instruction memory. Holds the
//  single-cycle core in reset until the image is fully loaded.
// PARAMETERS
//  BASE_ADDR   32'h0000_0000  byte address of the first instruction word written
//  DEPTH_WORDS 64             capacity of instruction memory in words; larger images are rejected
// PORTS
//  clk          in   1   system clock; single clock domain
//  reset        in   1   asynchronous, active-high reset
//  start        in   1   1-cycle pulse: begin a new load (honoured only in IDLE, DONE, ERR)
//  byte_valid   in   1   byte_data is valid this cycle
//  byte_data    in   8   incoming stream byte
//  byte_ready   out  1   loader accepts byte this cycle; transfer = byte_valid & byte_ready
//  mem_we       out  1   instruction-memory write strobe, one cycle per word
//  mem_addr     out  32  byte address of the word being written (word aligned)
//  mem_wdata    out  32  assembled instruction word
//  cpu_reset    out  1   hold core in reset; low only once a load has completed
//  busy         out  1   load in progress (LEN_LO, LEN_HI, DATA, WRITE)
//  done         out  1   level: last load completed successfully
//  err_overflow out  1   level: declared length > DEPTH_WORDS
//  word_count   out  16  words written in current/last load
// BEHAVIOUR
//  Stream format: len[7:0], len[15:8] (word count), then 4*len payload bytes, LSB first.
//  Reset (async): state IDLE; byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0,
//   cpu_reset=1, busy=0, done=0, err_overflow=0, word_count=0; partial word discarded.
//  States: IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
//   IDLE  : byte_ready=0; start -> LEN_LO, clears done/err_overflow/word_count, mem_addr=BASE_ADDR.
//   LEN_LO: byte_ready=1; on transfer latch len[7:0] -> LEN_HI.
//   LEN_HI: byte_ready=1; on transfer latch len[15:8]; len==0 -> DONE;
//           len>DEPTH_WORDS -> ERR; else -> DATA.
//   DATA  : byte_ready=1; byte k (k=0..3) -> mem_wdata[8k+7:8k]; after 4th transfer -> WRITE.
//   WRITE : byte_ready=0; mem_we=1 for exactly this cycle with mem_addr/mem_wdata stable;
//           next: word_count+1, mem_addr+4; word_count+1==len -> DONE else -> DATA.
//   DONE  : done=1, cpu_reset=0, byte_ready=0; start -> LEN_LO (cpu_reset re-asserts next cycle).
//   ERR   : err_overflow=1, cpu_reset=1, byte_ready=0, no writes; start -> LEN_LO.
//  Latency: 4th payload byte accepted in cycle N -> mem_we in cycle N+1; at most 1 byte/cycle,
//   steady-state 5 cycles/word with continuous byte_valid.
//  cpu_reset=1 in every state except DONE; registered, no glitches.
//  busy=1 in LEN_LO, LEN_HI, DATA, WRITE; start while busy is ignored.
//  byte_valid while byte_ready=0: byte not consumed, no state change (upstream must hold).
//  mem_addr arithmetic is 32-bit modulo 2^32; wrap cannot occur for legal len.
//  Bytes received after DONE/ERR are not accepted until next start.
//  reset mid-load: immediate return to IDLE; memory contents already written are not cleared.
// STRUCTURE
//  Shared include loader_defs.vh: state encodings (3-bit localparams), LEN_BYTES=2.
//  Sub-module word_packer: 2-bit byte index + 32-bit shift/insert register, outputs
//   word and word_full; cleared on reset and on start. FSM and address counter in top.
// TESTING
//  1. reset mid-DATA after 2 bytes -> all outputs at reset values, cpu_reset=1, no mem_we.
//  2. start; bytes 01 00 13 05 A0 00 -> one mem_we: addr 0x0, wdata 0x00A00513;
//     then done=1, cpu_reset=0, word_count=1.
//  3. len=3, continuous valid -> mem_we at addr 0x0,0x4,0x8 spaced 5 cycles; byte_ready low
//     exactly in each WRITE cycle; done after third write.
//  4. len=0 (00 00) -> DONE directly, zero mem_we, done=1, cpu_reset=0.
//  5. len=65 with DEPTH_WORDS=64 -> ERR, err_overflow=1, cpu_reset=1, byte_ready=0, no mem_we;
//     new start + len=1 load succeeds and clears err_overflow.
//  6. gaps in byte_valid and start pulses while busy -> identical memory image, start ignored.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// State encodings are fixed 3-bit values so waveforms stay readable across builds.
package imem_loader_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned LEN_W      = 16;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned IDX_W      = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  // States in which a load is in progress.
  function automatic logic is_busy(state_e s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_WRITE);
  endfunction

  // States in which an incoming stream byte may be consumed.
  function automatic logic takes_bytes(state_e s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word packer: byte k of each group of four lands in bits [8k+7:8k].
module word_packer
  import imem_loader_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_i,
  input  logic                load_i,
  input  logic [BYTE_W-1:0]   byte_i,
  output logic [DATA_W-1:0]   word_o,
  output logic                word_full_c
);

  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] word_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clear_i) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (load_i) begin
      word_q[{idx_q, 3'b000} +: BYTE_W] <= byte_i;
      idx_q                             <= idx_q + IDX_W'(1);
    end
  end

  // High on the transfer that completes the current word.
  assign word_full_c = load_i && (idx_q == IDX_W'(WORD_BYTES - 1));
  assign word_o      = word_q;

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte stream to instruction-memory writer; holds the core in reset
// until a complete image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        err_overflow,
  output logic [15:0] word_count
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  count_q, count_d;
  logic              byte_ready_q, byte_ready_d;
  logic              mem_we_q, mem_we_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic              pk_clear;
  logic              pk_load;
  logic              pk_full;
  logic [LEN_W-1:0]  len_full;
  logic [LEN_W-1:0]  count_inc;

  assign xfer      = byte_valid && byte_ready_q;
  assign len_full  = {byte_data, len_q[BYTE_W-1:0]};
  assign count_inc = count_q + LEN_W'(1);

  word_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (pk_clear),
    .load_i      (pk_load),
    .byte_i      (byte_data),
    .word_o      (mem_wdata),
    .word_full_c (pk_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      addr_q       <= BASE_ADDR;
      count_q      <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      cpu_reset_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      addr_q       <= addr_d;
      count_q      <= count_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      cpu_reset_q  <= cpu_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Next state plus outputs decoded from the next state, so every output leaves a flop.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    addr_d   = addr_q;
    count_d  = count_q;
    pk_clear = 1'b0;
    pk_load  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d  = ST_LEN_LO;
          count_d  = '0;
          addr_d   = BASE_ADDR;
          pk_clear = 1'b1;
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          len_d   = LEN_W'(byte_data);
          state_d = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (xfer) begin
          len_d = len_full;
          if (len_full == '0)                          state_d = ST_DONE;
          else if (32'(len_full) > 32'(DEPTH_WORDS))   state_d = ST_ERR;
          else                                         state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          pk_load = 1'b1;
          if (pk_full) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        count_d = count_inc;
        addr_d  = addr_q + ADDR_W'(WORD_BYTES);
        state_d = (count_inc == len_q) ? ST_DONE : ST_DATA;
      end
      default: state_d = ST_IDLE;
    endcase

    byte_ready_d = takes_bytes(state_d);
    mem_we_d     = (state_d == ST_WRITE);
    busy_d       = is_busy(state_d);
    cpu_reset_d  = (state_d != ST_DONE);
    done_d       = (state_d == ST_DONE);
    err_d        = (state_d == ST_ERR);
  end

  assign byte_ready   = byte_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = addr_q;
  assign cpu_reset    = cpu_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_overflow = err_q;
  assign word_count   = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes are queued as stimulus is
// issued and a negedge monitor pops and checks them as mem_we appears.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        err_overflow;
  logic [15:0] word_count;

  imem_loader #(.BASE_ADDR(32'h0000_0000), .DEPTH_WORDS(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .err_overflow (err_overflow),
    .word_count   (word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_writes = 0;
  int busy_cycles = 0;
  int rdy_low_busy = 0;

  logic [63:0] exp_q[$];
  int          we_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) begin
        busy_cycles++;
        if (!byte_ready) rdy_low_busy++;
      end
      if (mem_we) begin
        n_writes++;
        we_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", mem_addr, 32'hFFFF_FFFF);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("write_addr", mem_addr, e[63:32]);
          check("write_data", mem_wdata, e[31:0]);
          check("ready_low_in_write", 32'(byte_ready), 32'd0);
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present a byte and hold it until a transfer occurs; leaves byte_valid high.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (byte_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic [31:0] t;
    t = w;
    for (int k = 0; k < 4; k++) begin
      send_byte(t[7:0]);
      t = t >> 8;
      if (gap > 0) begin
        byte_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_settled(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    if (!ok) check({name, "_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err_overflow), 32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    int w0;
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(posedge clk); #1;
    check_reset_vals("por");
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: reset in the middle of a word
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB);
    byte_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_vals("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("midreset_writes", 32'(n_writes), 32'd0);

    // 2: single-word image
    exp_q.push_back({32'h0, 32'h00A0_0513});
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'h00A0_0513, 0);
    byte_valid = 1'b0;
    wait_settled("t2");
    check("t2_done", 32'(done), 32'd1);
    check("t2_cpu_reset", 32'(cpu_reset), 32'd0);
    check("t2_word_count", 32'(word_count), 32'd1);
    check("t2_writes", 32'(n_writes), 32'd1);

    // 3: three words, continuous stream
    exp_q.push_back({32'h0, 32'h1122_3344});
    exp_q.push_back({32'h4, 32'hDEAD_BEEF});
    exp_q.push_back({32'h8, 32'h0000_0093});
    we_cyc_q.delete();
    pulse_start();
    check("t3_cpu_reset_reasserted", 32'(cpu_reset), 32'd1);
    check("t3_busy", 32'(busy), 32'd1);
    busy_cycles = 0; rdy_low_busy = 0;
    send_byte(8'h03); send_byte(8'h00);
    send_word(32'h1122_3344, 0);
    send_word(32'hDEAD_BEEF, 0);
    send_word(32'h0000_0093, 0);
    byte_valid = 1'b0;
    wait_settled("t3");
    check("t3_write_count", 32'(we_cyc_q.size()), 32'd3);
    if (we_cyc_q.size() == 3) begin
      check("t3_spacing_01", 32'(we_cyc_q[1] - we_cyc_q[0]), 32'd5);
      check("t3_spacing_12", 32'(we_cyc_q[2] - we_cyc_q[1]), 32'd5);
    end
    check("t3_busy_cycles", 32'(busy_cycles), 32'd17);
    check("t3_ready_low_cycles", 32'(rdy_low_busy), 32'd3);
    check("t3_done", 32'(done), 32'd1);
    check("t3_word_count", 32'(word_count), 32'd3);

    // 4: empty image
    w0 = n_writes;
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    byte_valid = 1'b0;
    wait_settled("t4");
    check("t4_done", 32'(done), 32'd1);
    check("t4_cpu_reset", 32'(cpu_reset), 32'd0);
    check("t4_word_count", 32'(word_count), 32'd0);
    check("t4_writes", 32'(n_writes - w0), 32'd0);

    // 5: oversize image rejected, then recovery
    w0 = n_writes;
    pulse_start();
    send_byte(8'h41); send_byte(8'h00);
    byte_data = 8'h77;
    repeat (4) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    check("t5_err", 32'(err_overflow), 32'd1);
    check("t5_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t5_byte_ready", 32'(byte_ready), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_writes", 32'(n_writes - w0), 32'd0);
    exp_q.push_back({32'h0, 32'h1234_5678});
    pulse_start();
    check("t5_err_cleared", 32'(err_overflow), 32'd0);
    send_byte(8'h01); send_byte(8'h00);
    send_word(32'h1234_5678, 0);
    byte_valid = 1'b0;
    wait_settled("t5b");
    check("t5b_done", 32'(done), 32'd1);
    check("t5b_err", 32'(err_overflow), 32'd0);
    check("t5b_word_count", 32'(word_count), 32'd1);

    // 6: gapped stream with start pulses while busy
    exp_q.push_back({32'h0, 32'hCAFE_F00D});
    exp_q.push_back({32'h4, 32'h0BAD_C0DE});
    pulse_start();
    send_byte(8'h02);
    byte_valid = 1'b0;
    pulse_start();
    send_byte(8'h00);
    send_word(32'hCAFE_F00D, 2);
    pulse_start();
    send_word(32'h0BAD_C0DE, 1);
    byte_valid = 1'b0;
    wait_settled("t6");
    check("t6_done", 32'(done), 32'd1);
    check("t6_word_count", 32'(word_count), 32'd2);
    check("t6_cpu_reset", 32'(cpu_reset), 32'd0);

    repeat (3) @(posedge clk);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
